herloa_err_monitor: RTL
=======================

# herloa_err_monitor

On-chip error-statistics collector placed directly downstream of the HERLOA approximate adder. Each sample pairs the approximate sum with the exact sum. The block accumulates the error count, the total error distance, the maximum error distance and, optionally, the relative-error sum over a programmed number of samples. The results are the raw terms for ER, MED, NMED and MRED, so FPGA runs can replace long simulation sweeps.

## Interface
- N, 16, operand/sum width (matches adder N)
- CNT_W, 32, width of the sample and error counters
- ACC_W, 48, width of the distance and relative-error accumulators
- FRAC, 16, fraction bits of the relative-error quotient
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; clears statistics and begins a run
- num_samples  in  CNT_W  run length, sampled on accepted start; 0 means an immediate done
- in_valid  in  1  approx_s/exact_s valid
- in_ready  out  1  block accepts a sample this cycle
- approx_s  in  N  HERLOA sum S
- exact_s  in  N  exact sum (A+B)[N-1:0]
- busy  out  1  run in progress
- done  out  1  results final, held until next start
- sample_cnt  out  CNT_W  samples accepted
- err_cnt  out  CNT_W  samples with approx_s != exact_s
- sum_ed  out  ACC_W  Σ|approx_s − exact_s|
- max_ed  out  N  max |approx_s − exact_s|
- sat  out  1  sticky: some accumulator saturated
- zero_cnt  out  CNT_W  samples with exact_s == 0 (MRED only, else tied 0)
- sum_red  out  ACC_W  Σ floor((ED<<FRAC)/exact_s), exact_s != 0 (MRED only, else tied 0)

## Operation
- FSM states:
  - IDLE → RUN on start.
  - RUN → DRAIN when sample_cnt reaches num_samples.
  - DRAIN → DONE when the pipeline and divider are empty.
  - DONE → RUN on start.
- start in RUN/DRAIN is ignored.
- On an accepted start, all statistics outputs clear to 0 and sat clears in the same edge.
- Acceptance: in_valid && in_ready. in_ready = 1 only in RUN, with sample_cnt < num_samples and the divider idle.
- ED = unsigned magnitude |approx_s − exact_s|, N bits, with no modular wrap (0xFFFF vs 0x0000 gives 0xFFFF).
- err_cnt increments when ED != 0.
- max_ed updates when ED > max_ed.
- Accumulators saturate at all-ones. sat goes to 1 and is sticky until start or rst.
- busy = state ∈ {RUN, DRAIN}; done = state == DONE.

## Timing
- Reset: state IDLE; every output 0, including in_ready, busy, done and sat.
- A reset mid-run aborts the run with no partial result.
- Pipeline:
  - Stage 1 registers ED and the eq/zero flags at the acceptance edge t.
  - Stage 2 updates err_cnt/sum_ed/max_ed at edge t+1; they are visible from cycle t+2.
  - sample_cnt increments at edge t.
- Throughput without MRED: 1 sample/cycle.
- DRAIN lasts 1 cycle without MRED. done rises the cycle after the final accumulator update.
- A gap in in_valid has no effect on results.
- num_samples = 0: start → DRAIN → DONE, all results 0.

## Configuration
- HERLOA_ERRMON_MRED_EN defined:
  - Instantiates the divider, and zero_cnt/sum_red are live.
  - A sample with exact_s != 0 and ED != 0 starts the divider (N+FRAC cycles). in_ready is low during that time.
  - sum_red updates the cycle after the divider finishes.
  - exact_s == 0 increments zero_cnt and skips the divide.
  - ED == 0 adds 0 with no divide.
- Not defined: there is no divider, zero_cnt and sum_red are constant 0, and in_ready is never throttled.

## Structure
- Package herloa_errmon_pkg holds:
  - FSM state enum (IDLE, RUN, DRAIN, DONE)
  - default width constants
  - the saturating-add function
- Sub-module herloa_errmon_div: sequential restoring divider, (ED<<FRAC)/exact_s, start/busy/done handshake, present only under the macro.

## Test plan
- Equal sums: num_samples=4, approx=exact=0x1234 ×4 → err_cnt 0, sum_ed 0, max_ed 0, sample_cnt 4, done=1.
- Mixed errors: (0x0010, 0x0008), (0x0003, 0x0009), (0x0005, 0x0005) → err_cnt 2, sum_ed 14, max_ed 8.
- Wrap case: approx=0xFFFF, exact=0x0000 → max_ed 0xFFFF, sum_ed 0xFFFF. Then start again → all outputs clear to 0.
- Flow control: num_samples=3 with in_valid low on alternate cycles, plus start pulsed mid-RUN → results equal the back-to-back case, and the start is ignored.
- Reset mid-run: rst asserted after 2 of 5 samples → next cycle all outputs 0, state IDLE, in_ready 0.
- MRED (macro on):
  - approx=0x0003, exact=0x0004 → sum_red 0x4000, in_ready low for 32 cycles.
  - approx=0x0001, exact=0x0000 → zero_cnt 1, sum_red unchanged.

Source files
------------

// File: rtl/herloa_errmon_pkg.sv
// Shared types and helpers for the HERLOA error-statistics monitor.
// Holds the run-control FSM encoding, default widths and the saturating adder.
// Pure package: no clocked logic, no latency, no flow control.
package herloa_errmon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } errmon_state_e;

    localparam int unsigned DEF_N     = 16;
    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned DEF_ACC_W = 48;
    localparam int unsigned DEF_FRAC  = 16;

    // Working width of the saturating adder; accumulators up to this width.
    localparam int unsigned SAT_W = DEF_ACC_W;

    // Adds a + b and clamps to the all-ones value of a w-bit accumulator.
    // Result is {overflow, value}; overflow means the clamp was applied.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      w
    );
        logic [SAT_W:0] one;
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        one = {{SAT_W{1'b0}}, 1'b1};
        sum = {1'b0, a} + {1'b0, b};
        lim = (one << w) - one;
        if (sum > lim) begin
            return {1'b1, lim[SAT_W-1:0]};
        end
        return {1'b0, sum[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/herloa_errmon_div.sv
// Sequential restoring divider computing floor((ed << FRAC) / divisor).
// Latency: N+FRAC cycles of busy after the start edge, then a 1-cycle done pulse.
// Backpressure: start is ignored while busy; the caller must wait for busy low.
//
// Ports: clk/rst (sync, active-high), start, ed, divisor (must be non-zero),
//        busy, done (pulse, quo valid in that cycle), quo.
module herloa_errmon_div #(
    parameter int N    = 16,
    parameter int FRAC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      ed,
    input  logic [N-1:0]      divisor,
    output logic              busy,
    output logic              done,
    output logic [N+FRAC-1:0] quo
);

    localparam int QW = N + FRAC;
    localparam int CW = $clog2(QW + 1);

    // dq_q starts as the dividend and fills with quotient bits from the LSB
    // as the dividend bits shift out of the MSB.
    logic [QW-1:0] dq_q,   dq_d;
    logic [N-1:0]  rem_q,  rem_d;
    logic [N-1:0]  dvs_q,  dvs_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N:0]    trial;
    logic          ge;

    always_comb begin
        dq_d   = dq_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        trial  = {rem_q, dq_q[QW-1]};
        ge     = 1'b0;
        if (busy_q) begin
            ge = (trial >= {1'b0, dvs_q});
            // Remainder is always below the divisor, so the low N bits of
            // the subtraction are exact.
            rem_d = ge ? (trial[N-1:0] - dvs_q) : trial[N-1:0];
            dq_d  = {dq_q[QW-2:0], ge};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start) begin
            dq_d   = {ed, {FRAC{1'b0}}};
            rem_d  = '0;
            dvs_d  = divisor;
            cnt_d  = CW'(QW);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dq_q   <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dq_q   <= dq_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quo  = dq_q;

endmodule

// File: rtl/herloa_err_monitor.sv
// Error-statistics collector for the HERLOA approximate adder (ER/MED/NMED/MRED terms).
// Latency: sample accepted at edge t lands in err_cnt/sum_ed/max_ed at edge t+1.
// Backpressure: in_ready only in RUN with samples left; with HERLOA_ERRMON_MRED_EN
//               it also drops for N+FRAC cycles while a relative-error divide runs.
//
// Ports: clk, rst (sync, active-high), start/num_samples (run control),
//        in_valid/in_ready/approx_s/exact_s (sample stream),
//        busy/done, sample_cnt/err_cnt/sum_ed/max_ed/sat (statistics),
//        zero_cnt/sum_red (relative-error terms, live only with HERLOA_ERRMON_MRED_EN).
// Accumulator width ACC_W must not exceed herloa_errmon_pkg::SAT_W.
module herloa_err_monitor
    import herloa_errmon_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     approx_s,
    input  logic [N-1:0]     exact_s,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sum_ed,
    output logic [N-1:0]     max_ed,
    output logic             sat,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [ACC_W-1:0] sum_red
);

    errmon_state_e    state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
    logic [ACC_W-1:0] sum_red_q, sum_red_d;
    logic [N-1:0]     max_ed_q, max_ed_d;
    logic             sat_q, sat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Stage 1: per-sample distance and flags.
    logic             s1_vld_q, s1_vld_d;
    logic [N-1:0]     s1_ed_q, s1_ed_d;
    logic             s1_zero_q, s1_zero_d;

    logic [N-1:0]      ed;
    logic              rdy;
    logic              accept;
    logic              start_ok;
    logic              div_busy;
    logic              div_done;
    logic [N+FRAC-1:0] div_quo;
    logic [SAT_W:0]    ed_add;
    logic [SAT_W:0]    red_add;

`ifdef HERLOA_ERRMON_MRED_EN
    localparam bit MRED = 1'b1;

    // Divide launches straight from the accepted sample so the divider is
    // already busy in the following cycle and in_ready drops immediately.
    logic div_start;
    assign div_start = accept && (ed != '0) && (exact_s != '0);

    herloa_errmon_div #(
        .N    (N),
        .FRAC (FRAC)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .ed      (ed),
        .divisor (exact_s),
        .busy    (div_busy),
        .done    (div_done),
        .quo     (div_quo)
    );
`else
    localparam bit MRED = 1'b0;

    assign div_busy = 1'b0;
    assign div_done = 1'b0;
    assign div_quo  = '0;
`endif

    always_comb begin
        // Magnitude of the difference taken on the unsigned values, so a
        // full-scale gap (0xFFFF vs 0) is not folded back by modular wrap.
        ed       = (approx_s >= exact_s) ? (approx_s - exact_s) : (exact_s - approx_s);
        rdy      = (state_q == ST_RUN) && (sample_cnt_q < num_q) && !div_busy;
        accept   = in_valid && rdy;
        start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

        state_d      = state_q;
        num_d        = num_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        zero_cnt_d   = zero_cnt_q;
        sum_ed_d     = sum_ed_q;
        sum_red_d    = sum_red_q;
        max_ed_d     = max_ed_q;
        sat_d        = sat_q;

        s1_vld_d  = accept;
        s1_ed_d   = ed;
        s1_zero_d = (exact_s == '0);

        ed_add  = sat_add(SAT_W'(sum_ed_q), SAT_W'(s1_ed_q), ACC_W);
        red_add = sat_add(SAT_W'(sum_red_q), SAT_W'(div_quo), ACC_W);

        if (accept) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
        end

        // Stage 2: fold the registered sample into the statistics.
        if (s1_vld_q) begin
            if (s1_ed_q != '0) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            sum_ed_d = ed_add[ACC_W-1:0];
            sat_d    = sat_d | ed_add[SAT_W];
            if (s1_ed_q > max_ed_q) begin
                max_ed_d = s1_ed_q;
            end
            if (MRED && s1_zero_q) begin
                zero_cnt_d = zero_cnt_q + CNT_W'(1);
            end
        end

        if (div_done) begin
            sum_red_d = red_add[ACC_W-1:0];
            sat_d     = sat_d | red_add[SAT_W];
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = (num_samples == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                // Leave on the edge that accepts the final sample, so DRAIN
                // coincides with that sample's stage-2 update.
                if (accept && (sample_cnt_d == num_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A divider done pulse in this cycle is consumed on this edge.
                if (!div_busy) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_ok) begin
            num_d        = num_samples;
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            zero_cnt_d   = '0;
            sum_ed_d     = '0;
            sum_red_d    = '0;
            max_ed_d     = '0;
            sat_d        = 1'b0;
            s1_vld_d     = 1'b0;
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            num_q        <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            zero_cnt_q   <= '0;
            sum_ed_q     <= '0;
            sum_red_q    <= '0;
            max_ed_q     <= '0;
            sat_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_ed_q      <= '0;
            s1_zero_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            zero_cnt_q   <= zero_cnt_d;
            sum_ed_q     <= sum_ed_d;
            sum_red_q    <= sum_red_d;
            max_ed_q     <= max_ed_d;
            sat_q        <= sat_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            s1_vld_q     <= s1_vld_d;
            s1_ed_q      <= s1_ed_d;
            s1_zero_q    <= s1_zero_d;
        end
    end

    assign in_ready   = rdy;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sum_ed     = sum_ed_q;
    assign max_ed     = max_ed_q;
    assign sat        = sat_q;
    assign zero_cnt   = zero_cnt_q;
    assign sum_red    = sum_red_q;

endmodule
